// File: rtl/tanh4_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit approximate tanh evaluator among NREQ requesters.
// Optional per-requester served counters are built when TANH_SCHED_STATS_EN is defined.
module tanh4_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
`ifdef TANH_SCHED_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [4*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [3:0]            resp_data,
  output logic [ID_W-1:0]       resp_id,
  input  logic                  resp_ready,
`ifdef TANH_SCHED_STATS_EN
  input  logic                  clr_cnt,
  output logic [NREQ*CNT_W-1:0] served_cnt,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [3:0]      resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic            slot_free;
  logic            grant_en;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;

  function automatic logic [3:0] tanh4(input logic [3:0] x);
    logic n;
    n = ((x[3] & x[2]) | x[1]) & ~(x[0] & ~(x[2] & x[1]));
    return {n, n, x[0], x[0]};
  endfunction

  // Index p+k reduced modulo NREQ; callers keep p < NREQ and k < NREQ.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[ID_W-1:0];
  endfunction

  assign slot_free = ~resp_valid_q | resp_ready;
  assign grant_en  = reset_n & en & (state_q == ST_RUN) & slot_free;

  // Cyclic priority search starting at ptr_q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_idx(ptr_q, k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (grant_en && gnt_found) begin
      ptr_d        = wrap_idx(gnt_idx, 1);
      resp_valid_d = 1'b1;
      resp_data_d  = tanh4(req_data[4*gnt_idx +: 4]);
      resp_id_d    = gnt_idx;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)             state_d = ST_RUN;
        else if (slot_free) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef TANH_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  // Saturating served counters; a clear wins over a same-cycle grant.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt)                             cnt_d[i] = '0;
      else if (req_ready[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter array is a handful of flops, not RAM, so it is reset like any other state.
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    served_cnt = '0;
    for (int i = 0; i < NREQ; i++) served_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_tanh4_rr_scheduler.sv
// Self-checking bench for tanh4_rr_scheduler: cycle model plus result scoreboard and directed scenarios.
// Stats scenario runs only when TANH_SCHED_STATS_EN is defined.
module tb_tanh4_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [3:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic        busy;
`ifdef TANH_SCHED_STATS_EN
  logic        clr_cnt;
  logic [15:0] served_cnt;
`endif

  int checks = 0;
  int errors = 0;

  tanh4_rr_scheduler #(
    .NREQ (4),
    .ID_W (2)
`ifdef TANH_SCHED_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
`ifdef TANH_SCHED_STATS_EN
    .clr_cnt    (clr_cnt),
    .served_cnt (served_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Hand-tabulated transfer function, independent of the gate equation.
  function automatic logic [3:0] tanh_ref(input logic [3:0] x);
    case (x)
      4'h0: return 4'h0;  4'h1: return 4'h3;  4'h2: return 4'hC;  4'h3: return 4'h3;
      4'h4: return 4'h0;  4'h5: return 4'h3;  4'h6: return 4'hC;  4'h7: return 4'hF;
      4'h8: return 4'h0;  4'h9: return 4'h3;  4'hA: return 4'hC;  4'hB: return 4'h3;
      4'hC: return 4'hC;  4'hD: return 4'h3;  4'hE: return 4'hC;  default: return 4'hF;
    endcase
  endfunction

  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_e;
  typedef struct {
    logic [1:0] id;
    logic [3:0] data;
  } resp_t;

  resp_t   sb[$];
  mstate_e st_m  = M_IDLE;
  int      ptr_m = 0;
  logic    rv_m  = 1'b0;
  int      cnt_m [4] = '{0, 0, 0, 0};

  // Cycle model: checks current outputs, then advances to the state after the next edge.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    logic       slot_free_m;
    int         g;
    resp_t      r;
    exp_rdy     = '0;
    g           = -1;
    slot_free_m = !rv_m || resp_ready;
    check("busy", busy, 32'(st_m != M_IDLE));
    check("resp_valid", resp_valid, rv_m);
    if (rv_m && sb.size() > 0) begin
      check("resp_data", resp_data, sb[0].data);
      check("resp_id", resp_id, sb[0].id);
    end
    if (reset_n && en && st_m == M_RUN && slot_free_m) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
`ifdef TANH_SCHED_STATS_EN
    for (int i = 0; i < 4; i++) check("served_cnt", served_cnt[4*i +: 4], cnt_m[i]);
`endif
    if (!reset_n) begin
      st_m  = M_IDLE;
      ptr_m = 0;
      rv_m  = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    end else begin
      if (rv_m && resp_ready) begin
        void'(sb.pop_front());
        rv_m = 1'b0;
      end
      if (g >= 0) begin
        r.id   = 2'(g);
        r.data = tanh_ref(req_data[4*g +: 4]);
        sb.push_back(r);
        rv_m  = 1'b1;
        ptr_m = (g + 1) % 4;
        if (cnt_m[g] < 15) cnt_m[g]++;
      end
`ifdef TANH_SCHED_STATS_EN
      if (clr_cnt) for (int i = 0; i < 4; i++) cnt_m[i] = 0;
`endif
      case (st_m)
        M_IDLE:  if (en) st_m = M_RUN;
        M_RUN:   if (!en) st_m = M_DRAIN;
        default: begin
          if (en)               st_m = M_RUN;
          else if (slot_free_m) st_m = M_IDLE;
        end
      endcase
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    en         = 1'b1;
    req_valid  = 4'b1111;
    req_data   = {4'h7, 4'h3, 4'h2, 4'hA};
    resp_ready = 1'b1;
`ifdef TANH_SCHED_STATS_EN
    clr_cnt    = 1'b0;
`endif
    tick(2);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_id", resp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);

    // Full round-robin sweep with no bubbles.
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", req_ready, 32'(1) << (k % 4));
      if (k > 0) begin
        check("rr_valid", resp_valid, 1);
        check("rr_id", resp_id, (k - 1) % 4);
      end
      tick();
    end

    // Single requester 2 with operand 0x6.
    req_valid = 4'b0100;
    req_data  = {4'h7, 4'h6, 4'h2, 4'hA};
    #1;
    check("single_grant", req_ready, 4'b0100);
    tick();
    check("single_valid", resp_valid, 1);
    check("single_data", resp_data, 4'hC);
    check("single_id", resp_id, 2);

    // Backpressure with result 0xF from requester 1 held.
    req_valid = 4'b0010;
    req_data  = {4'h7, 4'h6, 4'h7, 4'hA};
    tick();
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", req_ready, 0);
      check("bp_data", resp_data, 4'hF);
      check("bp_id", resp_id, 1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_grant", req_ready, 4'b0100);
    tick();
    check("bp_next_id", resp_id, 2);
    req_valid = 4'b0000;
    tick();

    // Drain sequence.
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    en        = 1'b0;
    #1;
    check("drain_no_grant", req_ready, 0);
    tick();
    check("drain_busy", busy, 1);
    check("drain_pending", resp_valid, 1);
    en = 1'b1;
    tick();
    check("drain_back_run", busy, 1);
    en = 1'b0;
    tick();
    resp_ready = 1'b1;
    tick();
    check("drain_popped", resp_valid, 0);
    check("drain_idle", busy, 0);

    // Reset while a result is pending and ptr=3.
    en         = 1'b1;
    req_valid  = 4'b0100;
    resp_ready = 1'b0;
    tick(2);
    check("pre_rst_valid", resp_valid, 1);
    req_valid = 4'b0000;
    reset_n   = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_valid", resp_valid, 0);
    req_valid  = 4'b1001;
    resp_ready = 1'b1;
    tick();
    check("post_rst_grant", req_ready, 4'b0001);
    tick();
    check("post_rst_second", req_ready, 4'b1000);

`ifdef TANH_SCHED_STATS_EN
    // Saturating counter for requester 1, then clear concurrent with a grant.
    req_valid = 4'b0000;
    clr_cnt   = 1'b1;
    tick();
    clr_cnt   = 1'b0;
    req_valid = 4'b0010;
    tick(14);
    check("cnt_14", served_cnt[7:4], 14);
    tick(3);
    check("cnt_sat", served_cnt[7:4], 15);
    clr_cnt = 1'b1;
    #1;
    check("clr_grant", req_ready, 4'b0010);
    tick();
    clr_cnt = 1'b0;
    check("cnt_clr", served_cnt[7:4], 0);
`endif

    req_valid = 4'b0000;
    en        = 1'b0;
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
